// File: rtl/reg_file_ctrl.sv
// Command-driven front end for a 2^W x N register file: accepts read/write/clear/dump
// commands on a valid/ready channel and returns read words on a valid/ready response channel.
module reg_file_ctrl #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [1:0]   i_cmd_op,
    input  logic [W-1:0] i_cmd_addr,
    input  logic [N-1:0] i_cmd_data,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [N-1:0] o_rsp_data,
    output logic [W-1:0] o_rsp_addr,
    output logic         o_rsp_last,
    output logic         o_rf_clr,
    output logic         o_rf_wr_en,
    output logic [W-1:0] o_rf_w_addr,
    output logic [N-1:0] o_rf_w_data,
    output logic [W-1:0] o_rf_r_addr,
    input  logic [N-1:0] i_rf_r_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR,
        S_READ,
        S_RSP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    state_t       r_state;
    state_t       w_next_state;
    logic         r_dump;
    logic [W-1:0] r_r_addr;
    logic [W-1:0] r_w_addr;
    logic [N-1:0] r_w_data;
    logic [N-1:0] r_rsp_data;
    logic [W-1:0] r_rsp_addr;
    logic         r_rsp_last;
    logic         w_accept;
    logic         w_last_addr;

    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_last_addr = (r_r_addr == {W{1'b1}});

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_WRITE: w_next_state = S_WRITE;
                        OP_CLEAR: w_next_state = S_CLEAR;
                        default:  w_next_state = S_READ;
                    endcase
                end
            end
            S_WRITE: w_next_state = S_IDLE;
            S_CLEAR: w_next_state = S_IDLE;
            S_READ:  w_next_state = S_RSP;
            S_RSP: begin
                // A dump keeps sweeping until the word at the top address is taken
                if (i_rsp_ready) begin
                    w_next_state = (r_dump && !w_last_addr) ? S_READ : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rf_wr_en  = 1'b0;
        o_rf_clr    = 1'b0;
        case (r_state)
            S_IDLE:  o_cmd_ready = 1'b1;
            S_WRITE: o_rf_wr_en  = 1'b1;
            S_CLEAR: o_rf_clr    = 1'b1;
            S_RSP:   o_rsp_valid = 1'b1;
            default: o_cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_dump     <= 1'b0;
            r_r_addr   <= '0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
            r_rsp_last <= 1'b0;
        end else begin
            if (w_accept) begin
                case (i_cmd_op)
                    OP_READ: begin
                        r_r_addr <= i_cmd_addr;
                        r_dump   <= 1'b0;
                    end
                    OP_WRITE: begin
                        r_w_addr <= i_cmd_addr;
                        r_w_data <= i_cmd_data;
                    end
                    OP_DUMP: begin
                        r_r_addr <= '0;
                        r_dump   <= 1'b1;
                    end
                    default: r_dump <= r_dump;
                endcase
            end
            if (r_state == S_READ) begin
                r_rsp_data <= i_rf_r_data;
                r_rsp_addr <= r_r_addr;
                r_rsp_last <= !r_dump || w_last_addr;
            end
            if ((r_state == S_RSP) && i_rsp_ready && r_dump && !w_last_addr) begin
                r_r_addr <= r_r_addr + W'(1);
            end
        end
    end

    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_addr  = r_rsp_addr;
    assign o_rsp_last  = r_rsp_last;
    assign o_rf_w_addr = r_w_addr;
    assign o_rf_w_data = r_w_data;
    assign o_rf_r_addr = r_r_addr;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl with a behavioural 4 x 8 register file
// attached to the controller's register-file pins.
module tb_reg_file_ctrl;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    logic       clk;
    logic       clrN;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [1:0] cmdAddr;
    logic [7:0] cmdData;
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspData;
    logic [1:0] rspAddr;
    logic       rspLast;
    logic       rfClr;
    logic       rfWrEn;
    logic [1:0] rfWAddr;
    logic [7:0] rfWData;
    logic [1:0] rfRAddr;
    logic [7:0] rfRData;

    logic [7:0] mem [4];
    int checks = 0;
    int fails = 0;
    int wrCount = 0;
    int clrCount = 0;
    int bothHigh = 0;

    typedef struct {
        logic [1:0] op;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] expData;
        logic [1:0] expAddr;
        logic       expLast;
    } vec_t;

    vec_t vecs[8];

    reg_file_ctrl #(.N(8), .W(2)) dut (
        .i_clk       (clk),
        .i_clr_n     (clrN),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_op    (cmdOp),
        .i_cmd_addr  (cmdAddr),
        .i_cmd_data  (cmdData),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_data  (rspData),
        .o_rsp_addr  (rspAddr),
        .o_rsp_last  (rspLast),
        .o_rf_clr    (rfClr),
        .o_rf_wr_en  (rfWrEn),
        .o_rf_w_addr (rfWAddr),
        .o_rf_w_data (rfWData),
        .o_rf_r_addr (rfRAddr),
        .i_rf_r_data (rfRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write and clear, combinational read, untouched by clrN
    always @(posedge clk) begin
        if (rfClr) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
        end else if (rfWrEn) begin
            mem[rfWAddr] <= rfWData;
        end
    end
    assign rfRData = mem[rfRAddr];

    always @(posedge clk) begin
        if (rfWrEn) wrCount <= wrCount + 1;
        if (rfClr) clrCount <= clrCount + 1;
        if (rfWrEn && rfClr) bothHigh <= bothHigh + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst cmdReady", 32'(cmdReady), 32'd1);
        checkOutput("rst rspValid", 32'(rspValid), 32'd0);
        checkOutput("rst rspLast", 32'(rspLast), 32'd0);
        checkOutput("rst rfClr", 32'(rfClr), 32'd0);
        checkOutput("rst rfWrEn", 32'(rfWrEn), 32'd0);
        checkOutput("rst rspData", 32'(rspData), 32'd0);
        checkOutput("rst rspAddr", 32'(rspAddr), 32'd0);
        checkOutput("rst rfWAddr", 32'(rfWAddr), 32'd0);
        checkOutput("rst rfWData", 32'(rfWData), 32'd0);
        checkOutput("rst rfRAddr", 32'(rfRAddr), 32'd0);
    endtask

    // Offer one command and return just after the edge that accepts it
    task automatic sendCmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data);
        int waitCycles = 0;
        while (!cmdReady && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("cmd accept in time", 32'(cmdReady), 32'd1);
        cmdOp    = op;
        cmdAddr  = addr;
        cmdData  = data;
        cmdValid = 1'b1;
        @(posedge clk);
        #1 cmdValid = 1'b0;
    endtask

    // Take one response word and return just after its handshake edge
    task automatic getRsp(output logic [7:0] data, output logic [1:0] addr, output logic last);
        int waitCycles = 0;
        rspReady = 1'b1;
        while (!rspValid && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("rsp arrives in time", 32'(rspValid), 32'd1);
        data = rspData;
        addr = rspAddr;
        last = rspLast;
        @(posedge clk);
        #1 rspReady = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] d;
        logic [1:0] a;
        logic       l;
        int         wrBefore;
        wrBefore = wrCount;
        sendCmd(v.op, v.addr, v.data);
        if (v.op == OP_WRITE) begin
            @(negedge clk);
            checkOutput("write strobe high", 32'(rfWrEn), 32'd1);
            checkOutput("write addr", 32'(rfWAddr), 32'(v.addr));
            checkOutput("write data", 32'(rfWData), 32'(v.data));
            @(negedge clk);
            checkOutput("write strobe dropped", 32'(rfWrEn), 32'd0);
            checkOutput("one write cycle", 32'(wrCount - wrBefore), 32'd1);
        end else if (v.op == OP_READ) begin
            getRsp(d, a, l);
            checkOutput("read data", 32'(d), 32'(v.expData));
            checkOutput("read addr", 32'(a), 32'(v.expAddr));
            checkOutput("read last", 32'(l), 32'(v.expLast));
        end
    endtask

    task automatic doClear();
        int clrBefore;
        clrBefore = clrCount;
        sendCmd(OP_CLEAR, 2'd0, 8'h00);
        @(negedge clk);
        checkOutput("clear strobe high", 32'(rfClr), 32'd1);
        checkOutput("no write during clear", 32'(rfWrEn), 32'd0);
        @(negedge clk);
        checkOutput("clear strobe dropped", 32'(rfClr), 32'd0);
        checkOutput("one clear cycle", 32'(clrCount - clrBefore), 32'd1);
    endtask

    task automatic doRead(input logic [1:0] addr, input logic [7:0] expData);
        vec_t v;
        v = '{op: OP_READ, addr: addr, data: 8'h00, expData: expData, expAddr: addr, expLast: 1'b1};
        applyStimulus(v);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] a;
        logic       l;
        logic [7:0] dumpExp [4];
        int         k;

        vecs[0] = '{op: OP_WRITE, addr: 2'd2, data: 8'hBB, expData: 8'h00, expAddr: 2'd0, expLast: 1'b0};
        vecs[1] = '{op: OP_WRITE, addr: 2'd3, data: 8'hF0, expData: 8'h00, expAddr: 2'd0, expLast: 1'b0};
        vecs[2] = '{op: OP_READ,  addr: 2'd2, data: 8'h00, expData: 8'hBB, expAddr: 2'd2, expLast: 1'b1};
        vecs[3] = '{op: OP_READ,  addr: 2'd3, data: 8'h00, expData: 8'hF0, expAddr: 2'd3, expLast: 1'b1};
        vecs[4] = '{op: OP_WRITE, addr: 2'd0, data: 8'h11, expData: 8'h00, expAddr: 2'd0, expLast: 1'b0};
        vecs[5] = '{op: OP_READ,  addr: 2'd0, data: 8'h00, expData: 8'h11, expAddr: 2'd0, expLast: 1'b1};
        vecs[6] = '{op: OP_WRITE, addr: 2'd1, data: 8'h22, expData: 8'h00, expAddr: 2'd0, expLast: 1'b0};
        vecs[7] = '{op: OP_READ,  addr: 2'd1, data: 8'h00, expData: 8'h22, expAddr: 2'd1, expLast: 1'b1};

        clrN     = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = 2'b00;
        cmdAddr  = 2'd0;
        cmdData  = 8'h00;
        rspReady = 1'b0;

        @(negedge clk);
        checkResetOutputs();
        @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);

        $display("[TB] clear then dump");
        doClear();
        sendCmd(OP_DUMP, 2'd3, 8'hAA);
        for (int i = 0; i < 4; i++) begin
            getRsp(d, a, l);
            checkOutput("cleared dump data", 32'(d), 32'h00);
            checkOutput("cleared dump addr", 32'(a), 32'(i));
            checkOutput("cleared dump last", 32'(l), (i == 3) ? 32'd1 : 32'd0);
        end
        #1 checkOutput("idle after dump", 32'(cmdReady), 32'd1);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        $display("[TB] dump with stall on word 1");
        dumpExp[0] = 8'h11;
        dumpExp[1] = 8'h22;
        dumpExp[2] = 8'hBB;
        dumpExp[3] = 8'hF0;
        sendCmd(OP_DUMP, 2'd0, 8'h00);
        getRsp(d, a, l);
        checkOutput("stall dump w0 data", 32'(d), 32'(dumpExp[0]));
        checkOutput("stall dump w0 addr", 32'(a), 32'd0);
        checkOutput("stall dump w0 last", 32'(l), 32'd0);
        k = 0;
        while (!rspValid && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall valid held", 32'(rspValid), 32'd1);
            checkOutput("stall data held", 32'(rspData), 32'(dumpExp[1]));
            checkOutput("stall addr held", 32'(rspAddr), 32'd1);
            checkOutput("stall not ready", 32'(cmdReady), 32'd0);
            @(negedge clk);
        end
        for (int i = 1; i < 4; i++) begin
            getRsp(d, a, l);
            checkOutput("stall dump data", 32'(d), 32'(dumpExp[i]));
            checkOutput("stall dump addr", 32'(a), 32'(i));
            checkOutput("stall dump last", 32'(l), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) checkOutput("busy mid dump", 32'(cmdReady), 32'd0);
        end
        #1 checkOutput("idle after last word", 32'(cmdReady), 32'd1);

        $display("[TB] clear after writes");
        @(negedge clk);
        doClear();
        doRead(2'd2, 8'h00);

        $display("[TB] reset during write");
        applyStimulus('{op: OP_WRITE, addr: 2'd1, data: 8'h33, expData: 8'h00, expAddr: 2'd0, expLast: 1'b0});
        sendCmd(OP_WRITE, 2'd1, 8'h55);
        @(negedge clk);
        checkOutput("write strobe before reset", 32'(rfWrEn), 32'd1);
        clrN = 1'b0;
        #1 checkResetOutputs();
        @(posedge clk);
        @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);
        doRead(2'd1, 8'h33);

        $display("[TB] back-to-back writes with cmdValid held");
        @(negedge clk);
        k = 0;
        cmdOp = OP_WRITE;
        for (int c = 0; c < 8; c++) begin
            checkOutput("ready alternates", 32'(cmdReady), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (cmdReady && k < 4) begin
                cmdAddr  = 2'(k);
                cmdData  = 8'hC0 + 8'(k);
                cmdValid = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        cmdValid = 1'b0;
        checkOutput("writes accepted", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) doRead(2'(i), 8'hC0 + 8'(i));

        checkOutput("strobes never overlap", 32'(bothHigh), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
